// File: rtl/la_csa_pkg.sv
// Shared definitions for the carry-save accumulator: state encoding and
// resolve-cycle helper.
package la_csa_pkg;

  // Accumulator control states (IDLE and ACCUM share one encoding)
  localparam logic [1:0] ST_ACC     = 2'd0;
  localparam logic [1:0] ST_RESOLVE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  // Number of chunked carry-propagate cycles needed to resolve an AW-bit pair
  function automatic int unsigned resolve_cycles(input int unsigned aw,
                                                 input int unsigned cw);
    return aw / cw;
  endfunction

endpackage

// File: rtl/la_csa42_row.sv
// Row of N 4:2 carry-save compressor cells with the cout->cin chain.
// The carry output is already weighted (shifted left by one, bit 0 = 0);
// the carry and cout leaving the top cell are dropped, so results wrap mod 2^N.
module la_csa42_row #(
  parameter int unsigned N = 24
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  input  logic [N-1:0] d,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry
);

  logic [N-1:0] cin_chain;

  assign cin_chain[0] = 1'b0;
  assign carry[0]     = 1'b0;

  // Each cell: first full adder on a,b,c; second on its sum, d and cin
  for (genvar i = 0; i < int'(N); i++) begin : g_cell
    logic s1;
    assign s1     = a[i] ^ b[i] ^ c[i];
    assign sum[i] = s1 ^ d[i] ^ cin_chain[i];
    if (i < int'(N) - 1) begin : g_chain
      assign cin_chain[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
      assign carry[i+1]     = (s1 & d[i]) | (s1 & cin_chain[i]) | (d[i] & cin_chain[i]);
    end
  end

endmodule

// File: rtl/la_csa_accum.sv
// Streaming multi-operand accumulator. Beats are folded into a redundant
// sum/carry pair through a 4:2 compressor row; on the last beat the pair is
// resolved to binary CW bits per cycle and held on a valid/ready output.
// Optional build macro: LA_CSAACC_SIGNED_EN (two's-complement operands,
// sign-extended to AW bits); default build zero-extends.
module la_csa_accum
  import la_csa_pkg::*;
#(
  parameter int unsigned W  = 16,
  parameter int unsigned AW = 24,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum
);

  localparam int unsigned K    = resolve_cycles(AW, CW);
  localparam int unsigned CNTW = (K > 1) ? $clog2(K) : 1;

  logic [1:0]      state_q;
  logic [1:0]      state_nx;
  logic [AW-1:0]   s_q;
  logic [AW-1:0]   c_q;
  logic [AW-1:0]   a_ext;
  logic [AW-1:0]   b_ext;
  logic [AW-1:0]   row_sum;
  logic [AW-1:0]   row_carry;
  logic [CNTW-1:0] cnt_q;
  logic            carry_q;
  logic [CW-1:0]   s_ch;
  logic [CW-1:0]   c_ch;
  logic [CW:0]     chunk_res;
  logic            accept;
  logic            out_fire;
  logic            last_chunk;

  assign accept     = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign last_chunk = (cnt_q == CNTW'(K - 1));

  // Operand extension to accumulator width
`ifdef LA_CSAACC_SIGNED_EN
  assign a_ext = {{(AW-W){in_a[W-1]}}, in_a};
  assign b_ext = {{(AW-W){in_b[W-1]}}, in_b};
`else
  assign a_ext = {{(AW-W){1'b0}}, in_a};
  assign b_ext = {{(AW-W){1'b0}}, in_b};
`endif

  // Fold the two operands into the running redundant pair
  la_csa42_row #(
    .N (AW)
  ) u_row (
    .a     (s_q),
    .b     (c_q),
    .c     (a_ext),
    .d     (b_ext),
    .sum   (row_sum),
    .carry (row_carry)
  );

  // Select the sum/carry chunk addressed by the resolve counter
  always_comb begin
    s_ch = '0;
    c_ch = '0;
    for (int unsigned k = 0; k < K; k++) begin
      if (cnt_q == CNTW'(k)) begin
        s_ch = s_q[k*CW +: CW];
        c_ch = c_q[k*CW +: CW];
      end
    end
    chunk_res = (CW+1)'(s_ch) + (CW+1)'(c_ch) + (CW+1)'(carry_q);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ACC;
    end else begin
      state_q <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_ACC:     if (accept && in_last) state_nx = ST_RESOLVE;
      ST_RESOLVE: if (last_chunk)        state_nx = ST_DONE;
      ST_DONE:    if (out_fire)          state_nx = ST_ACC;
      default:                           state_nx = ST_ACC;
    endcase
  end

  // Handshake flags follow the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_nx == ST_ACC);
      out_valid <= (state_nx == ST_DONE);
    end
  end

  // Accumulator pair, resolve chain and result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      out_sum <= '0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (accept) begin
            s_q <= row_sum;
            c_q <= row_carry;
            if (in_last) begin
              cnt_q   <= '0;
              carry_q <= 1'b0;
            end
          end
        end
        ST_RESOLVE: begin
          for (int unsigned k = 0; k < K; k++) begin
            if (cnt_q == CNTW'(k)) out_sum[k*CW +: CW] <= chunk_res[CW-1:0];
          end
          carry_q <= chunk_res[CW];
          cnt_q   <= last_chunk ? '0 : cnt_q + CNTW'(1);
        end
        ST_DONE: begin
          if (out_fire) begin
            s_q <= '0;
            c_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_la_csa_accum.sv
// Self-checking bench for la_csa_accum (W=16, AW=24, CW=8, K=3).
// Expected results are produced by a plain integer model and queued per
// accumulation; they are popped and compared when out_valid appears.
module tb_la_csa_accum;

  localparam int unsigned W  = 16;
  localparam int unsigned AW = 24;
  localparam int unsigned CW = 8;
  localparam int unsigned K  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] acc = '0;
  logic [AW-1:0] exp_q[$];

  always #5 clk = ~clk;

  la_csa_accum #(
    .W  (W),
    .AW (AW),
    .CW (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  function automatic logic [AW-1:0] ext(input logic [W-1:0] v);
`ifdef LA_CSAACC_SIGNED_EN
    return {{(AW-W){v[W-1]}}, v};
`else
    return AW'(v);
`endif
  endfunction

  // Present one beat at a negedge, wait for acceptance, update the model
  task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic last, output bit ok);
    int n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (ok) begin
      acc = acc + ext(a) + ext(b);
      if (last) begin
        exp_q.push_back(acc);
        acc = '0;
      end
    end
  endtask

  // Wait (bounded) for out_valid, counting negedges
  task automatic wait_out(output int cycles, output bit ok);
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    ok = out_valid;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++;
    if (out_sum !== '0) begin failures++; $display("FAIL reset_out_sum got=%h want=000000", out_sum); end
  endtask

  task automatic test_single();
    bit ok;
    int cyc;
    logic [AW-1:0] e;
    drive_beat(16'd3, 16'd5, 1'b1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_accept got=0 want=1"); end
    wait_out(cyc, ok);
    checks++;
    if (cyc != int'(K)) begin failures++; $display("FAIL single_latency got=%0d want=%0d", cyc, K); end
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL single_queue got=empty want=entry"); end
    else begin
      e = exp_q.pop_front();
      if (!ok || out_sum !== e) begin failures++; $display("FAIL single_sum got=%h valid=%b want=%h", out_sum, out_valid, e); end
    end
    ack();
  endtask

  task automatic test_multi(input string name, input int beats);
    bit ok;
    bit all_ok = 1'b1;
    int cyc;
    logic [AW-1:0] e;
    for (int i = 0; i < beats; i++) begin
      drive_beat(16'hFFFF, 16'hFFFF, (i == beats - 1), ok);
      all_ok &= ok;
    end
    checks++;
    if (!all_ok) begin failures++; $display("FAIL %s_accept got=0 want=1", name); end
    wait_out(cyc, ok);
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL %s_queue got=empty want=entry", name); end
    else begin
      e = exp_q.pop_front();
      if (!ok || out_sum !== e) begin failures++; $display("FAIL %s_sum got=%h valid=%b want=%h", name, out_sum, out_valid, e); end
    end
    ack();
  endtask

  task automatic test_hold();
    bit ok;
    int cyc;
    logic [AW-1:0] e;
    drive_beat(16'h1234, 16'h0042, 1'b1, ok);
    wait_out(cyc, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL hold_timeout got=0 want=1"); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    in_valid = 1'b1;
    in_a     = 16'd9;
    in_b     = 16'd9;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_valid cyc=%0d got=%b want=1", i, out_valid); end
      checks++;
      if (out_sum !== e) begin failures++; $display("FAIL hold_sum cyc=%0d got=%h want=%h", i, out_sum, e); end
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready cyc=%0d got=%b want=0", i, in_ready); end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    ack();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_release_valid got=%b want=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_release_ready got=%b want=1", in_ready); end
    drive_beat(16'd1, 16'd1, 1'b1, ok);
    wait_out(cyc, ok);
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL hold_next_queue got=empty want=entry"); end
    else begin
      e = exp_q.pop_front();
      if (!ok || out_sum !== e) begin failures++; $display("FAIL hold_next_sum got=%h valid=%b want=%h", out_sum, out_valid, e); end
    end
    ack();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc;
    logic [AW-1:0] e;
    drive_beat(16'h00AA, 16'h0055, 1'b1, ok);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b want=1", in_ready); end
    checks++;
    if (out_sum !== '0) begin failures++; $display("FAIL midrst_sum got=%h want=000000", out_sum); end
    drive_beat(16'd7, 16'd0, 1'b1, ok);
    wait_out(cyc, ok);
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL midrst_next_queue got=empty want=entry"); end
    else begin
      e = exp_q.pop_front();
      if (!ok || out_sum !== e) begin failures++; $display("FAIL midrst_next_sum got=%h valid=%b want=%h", out_sum, out_valid, e); end
    end
    ack();
  endtask

  task automatic test_ext();
    bit ok;
    int cyc;
    logic [AW-1:0] e;
    logic [AW-1:0] lit;
`ifdef LA_CSAACC_SIGNED_EN
    lit = 24'hFFFFFF;
`else
    lit = 24'h00FFFF;
`endif
    drive_beat(16'hFFFF, 16'h0000, 1'b1, ok);
    wait_out(cyc, ok);
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL ext_queue got=empty want=entry"); end
    else begin
      e = exp_q.pop_front();
      if (!ok || out_sum !== e) begin failures++; $display("FAIL ext_sum got=%h valid=%b want=%h", out_sum, out_valid, e); end
    end
    checks++;
    if (out_sum !== lit) begin failures++; $display("FAIL ext_literal got=%h want=%h", out_sum, lit); end
    ack();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int cyc;
    int beats;
    logic [AW-1:0] e;
    for (int t = 0; t < 4; t++) begin
      beats = $urandom_range(1, 6);
      for (int i = 0; i < beats; i++) begin
        drive_beat(W'($urandom), W'($urandom), (i == beats - 1), ok);
      end
      wait_out(cyc, ok);
      checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_queue t=%0d got=empty want=entry", t); end
      else begin
        e = exp_q.pop_front();
        if (!ok || out_sum !== e) begin failures++; $display("FAIL b2b_sum t=%0d got=%h valid=%b want=%h", t, out_sum, out_valid, e); end
      end
      ack();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi("four", 4);
    test_multi("wrap", 256);
    test_hold();
    test_reset_mid();
    test_ext();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
